vjtag_mem_bridge: RTL and testbench
===================================

Name: vjtag_mem_bridge

Overview:
Parametrised successor of the 2-bit-IR virtual JTAG endpoint. It turns the virtual JTAG instruction and DR states into addressed memory read/write requests on a valid/ready interface. Runs entirely in the tck domain; any crossing to the system clock is done downstream. Adds IR decoding, a variable-length DR shifter, an address register with auto-increment, a request FSM and sticky status.

Parameters:
- IR_W, 2, instruction register width (min 2).
- DATA_W, 8, data DR length and memory data width.
- ADDR_W, 16, address DR length and memory address width.

Ports:
- tck  in  1  clock (virtual JTAG TCK).
- rst_n  in  1  asynchronous active-low reset.
- tdi  in  1  serial data in.
- tdo  out  1  serial data out.
- ir_in  in  IR_W  current virtual instruction.
- ir_out  out  IR_W  status readback.
- virtual_state_cdr  in  1  capture-DR.
- virtual_state_sdr  in  1  shift-DR.
- virtual_state_udr  in  1  update-DR.
- virtual_state_uir  in  1  update-IR.
- req_valid  out  1  request pending.
- req_ready  in  1  request accepted.
- req_we  out  1  1 = write, 0 = read.
- req_addr  out  ADDR_W  request address.
- req_wdata  out  DATA_W  write data.
- rsp_valid  in  1  read data valid (one cycle).
- rsp_rdata  in  DATA_W  read data.
- busy  out  1  FSM not IDLE.
- overrun  out  1  sticky: update-DR was dropped.

Behaviour:
- Reset: tdo=0, ir_out=0, req_valid=0, req_we=0, req_addr=0, req_wdata=0, busy=0, overrun=0.
- Reset also clears the address register, the read buffer (rd_buf), the shifter and the bypass bit. An asserted rst_n mid-transaction aborts it immediately.
- IR decode: 0=BYPASS, 1=ADDR, 2=WRITE, 3=READ. Any other code (IR_W>2) behaves as BYPASS.
- Shift length: len = ADDR_W for ADDR, DATA_W for WRITE/READ, 1 for BYPASS.
- Shifting is LSB first. Each tck with sdr: sr <= sr>>1 and sr[len-1] <= tdi; tdo = sr[0], registered.
- BYPASS uses a separate 1-bit register that is cleared on cdr.
- Capture (cdr):
  - ADDR: sr = addr.
  - WRITE: sr = 0.
  - READ: sr = rd_buf, the registered value present before this edge. A rsp_valid on the same edge is not visible to this capture.
- Update (udr):
  - ADDR: addr <= sr[ADDR_W-1:0]; overrun cleared.
  - WRITE: issue a write with {addr, sr[DATA_W-1:0]}.
  - READ: issue a read at addr; its data lands in rd_buf. READ is therefore prefetching: data from update N is captured at DR scan N+1.
- Issue accepted only in IDLE: request fields latch, req_valid=1 on the next edge, and addr increments (see optional feature).
- Issue while not IDLE: request dropped, overrun=1, addr unchanged.
- Request FSM:
  - IDLE -> REQ on an accepted issue.
  - REQ holds req_valid and all fields stable until req_valid&&req_ready. Then write -> IDLE; read -> WAIT.
  - WAIT -> IDLE on rsp_valid, with rd_buf <= rsp_rdata.
  - rsp_valid in any other state is ignored.
  - Minimum write occupancy is 1 cycle in REQ.
- Address wraps modulo 2^ADDR_W.
- udr with ADDR while busy: the address load still happens. The in-flight request keeps its latched address.
- uir: no effect on the FSM.
- ir_out = {0…, busy, overrun}, zero-extended to IR_W.

Optional Feature:
- Macro VJTAG_AUTOINC_EN.
- Defined: each accepted WRITE/READ issue increments addr by 1 on the issue edge, wrapping at 2^ADDR_W.
- Undefined: addr changes only on an ADDR update; repeated WRITE/READ updates hit the same address.

Decomposition:
- Package vjtag_pkg holds:
  - instruction codes INSTR_BYPASS/ADDR/WRITE/READ;
  - FSM state enum {IDLE, REQ, WAIT};
  - status bit positions STAT_OVERRUN=0, STAT_BUSY=1.
- One sub-module: vjtag_dr_shifter (MAX_W = max(DATA_W, ADDR_W) shift register with run-time length, parallel load on capture, parallel output, registered tdo).

Test Plan:
- ADDR scan 0x1234 (ADDR_W=16), then WRITE scan 0xA5, req_ready=1 -> single write with req_addr=0x1234, req_wdata=0xA5; req_valid high exactly 1 cycle; with VJTAG_AUTOINC_EN, an ADDR capture then shifts out 0x1235.
- ADDR 0x0010; READ update; responder returns 0x3C after 3 cycles; next READ scan -> tdo shifts out 0x3C LSB first; second read issued at 0x0011.
- WRITE update with req_ready=0 for 5 cycles, second WRITE update meanwhile -> req fields stable 5 cycles, second request dropped, overrun=1, ir_out=2'b11; ADDR update clears overrun.
- ADDR 0xFFFF, WRITE -> request at 0xFFFF, next addr 0x0000.
- IR=0 (and IR=5 with IR_W=3): shifting 1011 -> tdo returns the same bits delayed by one shift, no requests issued.
- rst_n low during WAIT -> all outputs return to reset values asynchronously, a later rsp_valid is ignored, and rd_buf=0.

Source files
------------

// File: rtl/vjtag_pkg.sv
// Shared definitions for the virtual JTAG memory bridge: instruction codes,
// request FSM states and status bit positions.
package vjtag_pkg;

    typedef enum logic [1:0] {
        INSTR_BYPASS = 2'd0,
        INSTR_ADDR   = 2'd1,
        INSTR_WRITE  = 2'd2,
        INSTR_READ   = 2'd3
    } instr_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam int unsigned STAT_OVERRUN = 0;
    localparam int unsigned STAT_BUSY    = 1;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vjtag_dr_shifter.sv
// Variable-length LSB-first DR shift register with parallel capture, a
// separate 1-bit bypass register and a registered tdo.
module vjtag_dr_shifter #(
    parameter int unsigned MAX_W = 16,
    parameter int unsigned LEN_W = $clog2(MAX_W + 1)
) (
    input  logic             tck,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] len_i,
    input  logic             bypass_i,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             tdi_i,
    input  logic [MAX_W-1:0] load_i,
    output logic [MAX_W-1:0] sr_o,
    output logic             tdo_o
);

    logic [MAX_W-1:0] sr_q, sr_d, sr_shift_s;
    logic             byp_q, byp_d;
    logic             tdo_q, tdo_d;

    assign sr_shift_s = {1'b0, sr_q[MAX_W-1:1]};

    // Next-state for the shifter, bypass bit and tdo; tdi enters at bit len-1
    always_comb begin
        sr_d  = sr_q;
        byp_d = byp_q;
        tdo_d = tdo_q;
        if (capture_i) begin
            sr_d  = load_i;
            byp_d = 1'b0;
        end else if (shift_i) begin
            for (int i = 0; i < int'(MAX_W); i++) begin
                sr_d[i] = (i == int'(len_i) - 1) ? tdi_i : sr_shift_s[i];
            end
            byp_d = tdi_i;
            tdo_d = bypass_i ? byp_q : sr_q[0];
        end else begin
            sr_d  = sr_q;
        end
    end

    // Shifter state registers
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= {MAX_W{1'b0}};
            byp_q <= 1'b0;
            tdo_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            byp_q <= byp_d;
            tdo_q <= tdo_d;
        end
    end

    assign sr_o  = sr_q;
    assign tdo_o = tdo_q;

endmodule

// File: rtl/vjtag_mem_bridge.sv
// Virtual JTAG endpoint turning DR scans into memory read/write requests (tck domain).
// Optional build macro VJTAG_AUTOINC_EN: post-increment the address on every accepted issue.
module vjtag_mem_bridge
    import vjtag_pkg::*;
#(
    parameter int unsigned IR_W   = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              tck,
    input  logic              rst_n,
    input  logic              tdi,
    output logic              tdo,
    input  logic [IR_W-1:0]   ir_in,
    output logic [IR_W-1:0]   ir_out,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_udr,
    input  logic              virtual_state_uir,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned MAX_W = max_w(DATA_W, ADDR_W);
    localparam int unsigned LEN_W = $clog2(MAX_W + 1);
`ifdef VJTAG_AUTOINC_EN
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(0);
`endif

    instr_e             instr_s;
    logic [31:0]        ir_ext_s;
    logic [LEN_W-1:0]   len_s;
    logic [MAX_W-1:0]   load_s, sr_s;
    logic               addr_upd_s, issue_s, accept_s;
    logic [IR_W-1:0]    status_s;
    logic               unused_s;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  rd_buf_q, rd_buf_d;
    logic               req_valid_q, req_valid_d;
    logic               req_we_q, req_we_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [DATA_W-1:0]  req_wdata_q, req_wdata_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;

    assign ir_ext_s = 32'(ir_in);
    assign unused_s = virtual_state_uir;

    // Instruction decode; codes beyond READ fall back to BYPASS
    always_comb begin
        instr_s = INSTR_BYPASS;
        if (ir_ext_s < 32'd4) begin
            instr_s = instr_e'(ir_in[1:0]);
        end else begin
            instr_s = INSTR_BYPASS;
        end
    end

    // Scan length and capture value per instruction
    always_comb begin
        len_s  = LEN_W'(1);
        load_s = {MAX_W{1'b0}};
        case (instr_s)
            INSTR_ADDR: begin
                len_s  = LEN_W'(ADDR_W);
                load_s = MAX_W'(addr_q);
            end
            INSTR_WRITE: begin
                len_s  = LEN_W'(DATA_W);
                load_s = {MAX_W{1'b0}};
            end
            INSTR_READ: begin
                len_s  = LEN_W'(DATA_W);
                load_s = MAX_W'(rd_buf_q);
            end
            default: begin
                len_s  = LEN_W'(1);
                load_s = {MAX_W{1'b0}};
            end
        endcase
    end

    vjtag_dr_shifter #(
        .MAX_W (MAX_W),
        .LEN_W (LEN_W)
    ) u_shifter (
        .tck       (tck),
        .rst_n     (rst_n),
        .len_i     (len_s),
        .bypass_i  (instr_s == INSTR_BYPASS),
        .capture_i (virtual_state_cdr),
        .shift_i   (virtual_state_sdr),
        .tdi_i     (tdi),
        .load_i    (load_s),
        .sr_o      (sr_s),
        .tdo_o     (tdo)
    );

    assign addr_upd_s = virtual_state_udr && (instr_s == INSTR_ADDR);
    assign issue_s    = virtual_state_udr && ((instr_s == INSTR_WRITE) || (instr_s == INSTR_READ));
    assign accept_s   = issue_s && (state_q == IDLE);

    // Address register and sticky overrun; an ADDR load wins even while busy
    always_comb begin
        addr_d    = addr_q;
        overrun_d = overrun_q;
        if (addr_upd_s) begin
            addr_d    = sr_s[ADDR_W-1:0];
            overrun_d = 1'b0;
        end else if (accept_s) begin
            addr_d    = addr_q + ADDR_STEP;
            overrun_d = overrun_q;
        end else if (issue_s) begin
            addr_d    = addr_q;
            overrun_d = 1'b1;
        end else begin
            addr_d    = addr_q;
            overrun_d = overrun_q;
        end
    end

    // Request FSM: fields latch on issue and stay frozen until the handshake
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rd_buf_d    = rd_buf_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d     = REQ;
                    req_valid_d = 1'b1;
                    req_we_d    = (instr_s == INSTR_WRITE);
                    req_addr_d  = addr_q;
                    if (instr_s == INSTR_WRITE) begin
                        req_wdata_d = sr_s[DATA_W-1:0];
                    end else begin
                        req_wdata_d = req_wdata_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (req_valid_q && req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = req_we_q ? IDLE : WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    rd_buf_d = rsp_rdata;
                    state_d  = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d     = IDLE;
                req_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Bridge state registers
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            rd_buf_q    <= {DATA_W{1'b0}};
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= {ADDR_W{1'b0}};
            req_wdata_q <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_buf_q    <= rd_buf_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    // Status word placed into the IR readback
    always_comb begin
        status_s               = {IR_W{1'b0}};
        status_s[STAT_OVERRUN] = overrun_q;
        status_s[STAT_BUSY]    = busy_q;
    end

    assign ir_out    = status_s;
    assign req_valid = req_valid_q;
    assign req_we    = req_we_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_vjtag_mem_bridge.sv
// Self-checking bench for vjtag_mem_bridge (IR_W=3, DATA_W=8, ADDR_W=16) with a
// transaction-level reference model of address, read buffer and overrun.
module tb_vjtag_mem_bridge;

    localparam int unsigned IR_W   = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 16;
`ifdef VJTAG_AUTOINC_EN
    localparam logic [15:0] STEP = 16'd1;
`else
    localparam logic [15:0] STEP = 16'd0;
`endif

    logic              tck = 1'b0;
    logic              rst_n = 1'b0;
    logic              tdi = 1'b0;
    logic              tdo;
    logic [IR_W-1:0]   ir_in = 3'd0;
    logic [IR_W-1:0]   ir_out;
    logic              vcdr = 1'b0, vsdr = 1'b0, vudr = 1'b0, vuir = 1'b0;
    logic              req_valid, req_we, busy, overrun;
    logic              req_ready = 1'b0;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid = 1'b0;
    logic [DATA_W-1:0] rsp_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_addr;
    logic [7:0]  m_rdbuf;

    always #5 tck = ~tck;

    vjtag_mem_bridge #(.IR_W(IR_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .tck(tck), .rst_n(rst_n), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out),
        .virtual_state_cdr(vcdr), .virtual_state_sdr(vsdr),
        .virtual_state_udr(vudr), .virtual_state_uir(vuir),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .busy(busy), .overrun(overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic scan(input logic [2:0] ir, input logic [15:0] val, input int len, output logic [15:0] got);
        ir_in = ir;
        vcdr = 1'b1;
        tick();
        vcdr = 1'b0;
        got = 16'h0000;
        for (int i = 0; i < len; i++) begin
            tdi  = val[i];
            vsdr = 1'b1;
            tick();
            got[i] = tdo;
        end
        vsdr = 1'b0;
        tdi  = 1'b0;
    endtask

    task automatic update();
        vudr = 1'b1;
        tick();
        vudr = 1'b0;
    endtask

    task automatic do_addr(input logic [15:0] v);
        logic [15:0] got;
        scan(3'd1, v, 16, got);
        check("addr_capture", 32'(got), 32'(m_addr));
        update();
        m_addr = v;
        check("addr_overrun_clr", 32'(overrun), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] d, input int rdy_dly);
        logic [15:0] got;
        logic [15:0] exp_a;
        scan(3'd2, {8'h00, d}, 8, got);
        check("wr_capture", 32'(got), 32'd0);
        req_ready = 1'b0;
        update();
        exp_a = m_addr;
        m_addr = m_addr + STEP;
        check("wr_valid", 32'(req_valid), 32'd1);
        check("wr_we", 32'(req_we), 32'd1);
        check("wr_addr", 32'(req_addr), 32'(exp_a));
        check("wr_data", 32'(req_wdata), 32'(d));
        check("wr_busy", 32'(busy), 32'd1);
        for (int k = 0; k < rdy_dly; k++) begin
            tick();
            check("wr_hold", 32'({req_valid, req_we, req_addr, req_wdata}), 32'({1'b1, 1'b1, exp_a, d}));
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("wr_done_valid", 32'(req_valid), 32'd0);
        check("wr_done_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_read(input int rdy_dly, input int rsp_dly, input logic [7:0] rdata);
        logic [15:0] got;
        logic [15:0] exp_a;
        scan(3'd3, 16'($urandom), 8, got);
        check("rd_capture", 32'(got), 32'(m_rdbuf));
        req_ready = 1'b0;
        update();
        exp_a = m_addr;
        m_addr = m_addr + STEP;
        check("rd_valid", 32'(req_valid), 32'd1);
        check("rd_we", 32'(req_we), 32'd0);
        check("rd_addr", 32'(req_addr), 32'(exp_a));
        for (int k = 0; k < rdy_dly; k++) begin
            tick();
            check("rd_hold", 32'({req_valid, req_addr}), 32'({1'b1, exp_a}));
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("rd_accepted", 32'({req_valid, busy}), 32'({1'b0, 1'b1}));
        for (int k = 0; k < rsp_dly; k++) begin
            tick();
            check("rd_wait_busy", 32'(busy), 32'd1);
        end
        rsp_valid = 1'b1;
        rsp_rdata = rdata;
        tick();
        rsp_valid = 1'b0;
        rsp_rdata = 8'(~rdata);
        m_rdbuf = rdata;
        check("rd_done_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_bypass(input logic [2:0] ir, input logic [3:0] bits);
        logic [15:0] got;
        logic [3:0]  exp_bits;
        scan(ir, {12'h000, bits}, 4, got);
        exp_bits = {bits[2:0], 1'b0};
        check("byp_tdo", 32'(got), 32'(exp_bits));
        update();
        check("byp_no_req", 32'({req_valid, busy}), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({tdo, ir_out, req_valid, req_we, req_addr, req_wdata, busy, overrun}), 32'd0);
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] exp_a;
        int unsigned op;

        m_addr  = 16'h0000;
        m_rdbuf = 8'h00;

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        tick();

        // uir pulse has no visible effect
        vuir = 1'b1;
        tick();
        vuir = 1'b0;
        check("uir_no_effect", 32'({busy, req_valid}), 32'd0);

        // Single write at 0x1234
        do_addr(16'h1234);
        do_write(8'hA5, 0);
        tick();
        check("wr_single_pulse", 32'(req_valid), 32'd0);
        do_addr(16'h0010);

        // Prefetching read, then a second read at the next address
        do_read(0, 2, 8'h3C);
        do_read(1, 0, 8'h96);
        do_read(0, 1, 8'h01);

        // rsp_valid while idle is ignored
        rsp_valid = 1'b1;
        rsp_rdata = 8'hEE;
        tick();
        rsp_valid = 1'b0;
        check("idle_rsp_busy", 32'(busy), 32'd0);
        do_read(0, 0, 8'h44);

        // Overrun: second WRITE while the first is stalled
        do_addr(16'h0200);
        scan(3'd2, 16'h005A, 8, got);
        req_ready = 1'b0;
        update();
        exp_a = m_addr;
        m_addr = m_addr + STEP;
        check("ovr_first_valid", 32'(req_valid), 32'd1);
        scan(3'd2, 16'h00C3, 8, got);
        check("ovr_second_capture", 32'(got), 32'd0);
        check("ovr_stable", 32'({req_valid, req_addr, req_wdata}), 32'({1'b1, exp_a, 8'h5A}));
        update();
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_ir_out", 32'(ir_out), 32'(3'b011));
        check("ovr_fields_kept", 32'({req_addr, req_wdata}), 32'({exp_a, 8'h5A}));
        do_addr(16'h0400);
        check("ovr_addr_load_busy", 32'({req_valid, req_addr}), 32'({1'b1, exp_a}));
        check("ovr_ir_after_addr", 32'(ir_out), 32'(3'b010));
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("ovr_release", 32'({req_valid, ir_out}), 32'({1'b0, 3'b000}));
        do_write(8'h11, 2);

        // Address wrap
        do_addr(16'hFFFF);
        do_write(8'h7E, 0);
        do_addr(16'h0000);

        // Bypass: IR=0 and out-of-range IR=5
        do_bypass(3'd0, 4'b1101);
        do_bypass(3'd5, 4'b1101);
        do_bypass(3'd7, 4'b0110);
        do_addr(16'h0000);

        // Randomised transaction mix against the model
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: do_addr(16'($urandom));
                1: do_write(8'($urandom), int'($urandom_range(0, 3)));
                2: do_read(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 8'($urandom));
                default: do_bypass(3'($urandom_range(4, 7)), 4'($urandom));
            endcase
        end

        // Asynchronous reset while waiting for read data
        do_addr(16'h0050);
        do_write(8'h33, 0);
        do_read(0, 0, 8'h5C);
        scan(3'd3, 16'h0000, 8, got);
        check("rst_pre_capture", 32'(got), 32'(m_rdbuf));
        update();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("rst_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async_outputs");
        m_addr  = 16'h0000;
        m_rdbuf = 8'h00;
        #2;
        rst_n = 1'b1;
        tick();
        rsp_valid = 1'b1;
        rsp_rdata = 8'hEE;
        tick();
        rsp_valid = 1'b0;
        check("rst_late_rsp", 32'({busy, req_valid}), 32'd0);
        do_read(0, 0, 8'h21);
        do_addr(16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
